// File: rtl/cv32e40s_lsu_write_buffer_if.sv
// OBI data request type and the handshake bundle around the LSU write buffer.
// "slave" is the buffer's view; "master" is the response filter / OBI side.
package cv32e40s_lsu_wb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_data_req_t;
endpackage

interface cv32e40s_lsu_write_buffer_if;
  import cv32e40s_lsu_wb_pkg::*;

  logic          valid_i;
  obi_data_req_t trans_i;
  logic          ready_o;
  logic          valid_o;
  obi_data_req_t trans_o;
  logic          ready_i;
  logic          busy_o;
  logic          full_o;
  logic          empty_o;

  modport slave (
    input  valid_i, trans_i, ready_i,
    output ready_o, valid_o, trans_o, busy_o, full_o, empty_o
  );

  modport master (
    output valid_i, trans_i, ready_i,
    input  ready_o, valid_o, trans_o, busy_o, full_o, empty_o
  );
endinterface

// File: rtl/cv32e40s_lsu_write_buffer.sv
// In-order buffer for bufferable stores between the LSU response filter and OBI.
// Non-bufferable transfers bypass only when empty, so bus order equals program order.
module cv32e40s_lsu_write_buffer
  import cv32e40s_lsu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e40s_lsu_write_buffer_if.slave    bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  obi_data_req_t    r_fifo [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;

  logic             w_bufferable;
  logic             w_empty;
  logic             w_full;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rptr_next;
  logic [PTR_W-1:0] w_wptr_next;

  assign w_bufferable = bus.trans_i.we && bus.trans_i.memtype[0];
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);

  // When full, ready is forced low even if the head pops this cycle, keeping
  // ready_i out of the ready_o path whenever anything is buffered.
  always_comb begin
    w_ready = 1'b0;
    if (w_full) begin
      w_ready = 1'b0;
    end else if (w_empty) begin
      w_ready = w_bufferable ? 1'b1 : bus.ready_i;
    end else begin
      w_ready = w_bufferable;
    end
  end

  // A bufferable store that bypasses and completes immediately is not stored.
  assign w_push = bus.valid_i && w_ready && w_bufferable && !(w_empty && bus.ready_i);
  assign w_pop  = !w_empty && bus.ready_i;

  assign w_rptr_next = (r_rptr == LAST_PTR) ? '0 : r_rptr + PTR_W'(1);
  assign w_wptr_next = (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= w_wptr_next;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_next;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo[r_wptr] <= bus.trans_i;
    end
  end

  // A stalled bypassed store is pushed, then re-presented from the head unchanged.
  always_comb begin
    bus.valid_o = bus.valid_i;
    bus.trans_o = bus.trans_i;
    if (!w_empty) begin
      bus.valid_o = 1'b1;
      bus.trans_o = r_fifo[r_rptr];
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.busy_o  = !w_empty;
  assign bus.empty_o = w_empty;
  assign bus.full_o  = w_full;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_pop && w_empty));

endmodule

// File: tb/tb_cv32e40s_lsu_write_buffer.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// model of the write buffer and of the expected bus order.
module tb_cv32e40s_lsu_write_buffer;
  import cv32e40s_lsu_wb_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40s_lsu_write_buffer_if bus();

  cv32e40s_lsu_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic obi_data_req_t mk(input logic [31:0] a, input logic we, input logic bufb);
    obi_data_req_t t;
    t         = '0;
    t.addr    = a;
    t.we      = we;
    t.be      = 4'hF;
    t.wdata   = a ^ 32'hA5A5_0000;
    t.memtype = {1'b0, bufb};
    return t;
  endfunction

  task automatic set_in(input logic v, input obi_data_req_t t, input logic r);
    bus.valid_i = v;
    bus.trans_i = t;
    bus.ready_i = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obi_data_req_t t;
    rst_n = 1'b0;
    t = mk(32'h55, 1'b1, 1'b1);
    set_in(1'b1, t, 1'b0);
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.full_o !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", bus.full_o); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", bus.empty_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL rst_valid: got %b want 1", bus.valid_o); end
    total++; if (bus.trans_o !== t) begin bad++; $display("FAIL rst_trans: got %h want %h", bus.trans_o, t); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready_buf: got %b want 1", bus.ready_o); end
    t = mk(32'h66, 1'b0, 1'b0);
    set_in(1'b1, t, 1'b1);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready_nb1: got %b want 1", bus.ready_o); end
    set_in(1'b1, t, 1'b0);
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready_nb0: got %b want 0", bus.ready_o); end
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid0: got %b want 0", bus.valid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_bypass_load();
    set_in(1'b1, mk(32'h100, 1'b0, 1'b0), 1'b1);
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL byp_valid: got %b want 1", bus.valid_o); end
    total++; if (bus.trans_o.addr !== 32'h100) begin bad++; $display("FAIL byp_addr: got %h want 100", bus.trans_o.addr); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL byp_ready: got %b want 1", bus.ready_o); end
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL byp_empty: got %b want 1", bus.empty_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL byp_busy: got %b want 0", bus.busy_o); end
    $display("bypass load 0x100 done");
  endtask

  task automatic test_stalled_store();
    set_in(1'b1, mk(32'h200, 1'b1, 1'b1), 1'b0);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL stall_ready0: got %b want 1", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h200) begin bad++; $display("FAIL stall_addr0: got %h want 200", bus.trans_o.addr); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      set_in(1'b0, '0, (c == 3));
      total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL stall_busy c%0d: got %b want 1", c, bus.busy_o); end
      total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d: got %b want 1", c, bus.valid_o); end
      total++; if (bus.trans_o.addr !== 32'h200) begin bad++; $display("FAIL stall_addr c%0d: got %h want 200", c, bus.trans_o.addr); end
    end
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL stall_empty4: got %b want 1", bus.empty_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL stall_busy4: got %b want 0", bus.busy_o); end
    $display("stalled store 0x200 done");
  endtask

  task automatic test_full();
    set_in(1'b1, mk(32'h10, 1'b1, 1'b1), 1'b0);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL full_rdy10: got %b want 1", bus.ready_o); end
    tick();
    set_in(1'b1, mk(32'h14, 1'b1, 1'b1), 1'b0);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL full_rdy14: got %b want 1", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h10) begin bad++; $display("FAIL full_head10: got %h want 10", bus.trans_o.addr); end
    tick();
    set_in(1'b1, mk(32'h18, 1'b1, 1'b1), 1'b0);
    total++; if (bus.full_o !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", bus.full_o); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL full_rdy18a: got %b want 0", bus.ready_o); end
    tick();
    set_in(1'b1, mk(32'h18, 1'b1, 1'b1), 1'b1);
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL full_rdy_popcycle: got %b want 0", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h10) begin bad++; $display("FAIL full_pop10: got %h want 10", bus.trans_o.addr); end
    tick();
    set_in(1'b1, mk(32'h18, 1'b1, 1'b1), 1'b0);
    total++; if (bus.full_o !== 1'b0 || bus.empty_o !== 1'b0) begin bad++; $display("FAIL full_cnt1: got full=%b empty=%b want 0 0", bus.full_o, bus.empty_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL full_rdy18b: got %b want 1", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h14) begin bad++; $display("FAIL full_head14: got %h want 14", bus.trans_o.addr); end
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.full_o !== 1'b1) begin bad++; $display("FAIL full_refill: got %b want 1", bus.full_o); end
    tick();
    set_in(1'b0, '0, 1'b1);
    total++; if (bus.trans_o.addr !== 32'h14) begin bad++; $display("FAIL full_drain14: got %h want 14", bus.trans_o.addr); end
    tick();
    set_in(1'b0, '0, 1'b1);
    total++; if (bus.trans_o.addr !== 32'h18) begin bad++; $display("FAIL full_drain18: got %h want 18", bus.trans_o.addr); end
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL full_drained: got %b want 1", bus.empty_o); end
    $display("full scenario 0x10/0x14/0x18 done");
  endtask

  task automatic test_order();
    set_in(1'b1, mk(32'h20, 1'b1, 1'b1), 1'b0);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL ord_rdy20: got %b want 1", bus.ready_o); end
    tick();
    set_in(1'b1, mk(32'h30, 1'b0, 1'b0), 1'b0);
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL ord_rdy30a: got %b want 0", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h20) begin bad++; $display("FAIL ord_head20a: got %h want 20", bus.trans_o.addr); end
    tick();
    set_in(1'b1, mk(32'h30, 1'b0, 1'b0), 1'b1);
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL ord_rdy30b: got %b want 0", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h20) begin bad++; $display("FAIL ord_head20b: got %h want 20", bus.trans_o.addr); end
    tick();
    set_in(1'b1, mk(32'h30, 1'b0, 1'b0), 1'b1);
    total++; if (bus.trans_o.addr !== 32'h30) begin bad++; $display("FAIL ord_byp30: got %h want 30", bus.trans_o.addr); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL ord_rdy30c: got %b want 1", bus.ready_o); end
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL ord_empty: got %b want 1", bus.empty_o); end
    $display("order 0x20 then 0x30 done");
  endtask

  task automatic test_push_pop();
    set_in(1'b1, mk(32'h40, 1'b1, 1'b1), 1'b0);
    tick();
    set_in(1'b1, mk(32'h44, 1'b1, 1'b1), 1'b1);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL pp_ready: got %b want 1", bus.ready_o); end
    total++; if (bus.trans_o.addr !== 32'h40) begin bad++; $display("FAIL pp_head40: got %h want 40", bus.trans_o.addr); end
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.trans_o.addr !== 32'h44) begin bad++; $display("FAIL pp_head44: got %h want 44", bus.trans_o.addr); end
    total++; if (bus.empty_o !== 1'b0 || bus.full_o !== 1'b0) begin bad++; $display("FAIL pp_cnt1: got empty=%b full=%b want 0 0", bus.empty_o, bus.full_o); end
    tick();
    set_in(1'b0, '0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL pp_empty: got %b want 1", bus.empty_o); end
    $display("push+pop 0x40/0x44 done");
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, mk(32'h50, 1'b1, 1'b1), 1'b0);
    tick();
    set_in(1'b1, mk(32'h54, 1'b1, 1'b1), 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.full_o !== 1'b1) begin bad++; $display("FAIL rm_full: got %b want 1", bus.full_o); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL rm_empty: got %b want 1", bus.empty_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.full_o !== 1'b0) begin bad++; $display("FAIL rm_full0: got %b want 0", bus.full_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_in(1'b1, mk(32'h60, 1'b0, 1'b0), 1'b0);
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL rm_valid1: got %b want 1", bus.valid_o); end
    total++; if (bus.trans_o.addr !== 32'h60) begin bad++; $display("FAIL rm_addr: got %h want 60", bus.trans_o.addr); end
    set_in(1'b0, '0, 1'b0);
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rm_valid0: got %b want 0", bus.valid_o); end
    $display("mid-operation reset done");
  endtask

  task automatic test_random();
    obi_data_req_t q[$];
    obi_data_req_t bus_exp[$];
    obi_data_req_t cur;
    obi_data_req_t exp_t;
    logic pend;
    logic r;
    logic exp_v;
    logic exp_r;
    logic bufb;
    logic acc;
    int   n;
    pend = 1'b0;
    cur  = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (!pend && cyc < 400 && $urandom_range(0, 3) != 0) begin
        cur         = mk($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cur.wdata   = $urandom;
        cur.memtype[1] = 1'($urandom_range(0, 1));
        pend        = 1'b1;
      end
      r = (cyc >= 400) ? 1'b1 : 1'($urandom_range(0, 1));
      set_in(pend, pend ? cur : obi_data_req_t'('0), r);

      n     = q.size();
      bufb  = cur.we && cur.memtype[0];
      exp_v = (n > 0) ? 1'b1 : pend;
      exp_t = (n > 0) ? q[0] : bus.trans_i;
      if (n == DEPTH)  exp_r = 1'b0;
      else if (n == 0) exp_r = bufb ? 1'b1 : r;
      else             exp_r = bufb;

      total++; if (bus.valid_o !== exp_v) begin bad++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, bus.valid_o, exp_v); end
      if (exp_v) begin
        total++; if (bus.trans_o !== exp_t) begin bad++; $display("FAIL rnd_trans cyc%0d: got %h want %h", cyc, bus.trans_o, exp_t); end
      end
      if (pend) begin
        total++; if (bus.ready_o !== exp_r) begin bad++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, bus.ready_o, exp_r); end
      end
      total++; if (bus.empty_o !== (n == 0) || bus.busy_o !== (n != 0) || bus.full_o !== (n == DEPTH)) begin
        bad++; $display("FAIL rnd_flags cyc%0d: got e=%b b=%b f=%b want count %0d", cyc, bus.empty_o, bus.busy_o, bus.full_o, n);
      end

      acc = pend && exp_r;
      if (acc) bus_exp.push_back(cur);
      if (bus.valid_o && bus.ready_i) begin
        total++;
        if (bus_exp.size() == 0) begin
          bad++; $display("FAIL rnd_order cyc%0d: got %h want no transfer", cyc, bus.trans_o);
        end else begin
          if (bus.trans_o !== bus_exp[0]) begin bad++; $display("FAIL rnd_order cyc%0d: got %h want %h", cyc, bus.trans_o, bus_exp[0]); end
          void'(bus_exp.pop_front());
        end
        $display("xfer cyc%0d addr=%h we=%b", cyc, bus.trans_o.addr, bus.trans_o.we);
      end

      if (n > 0 && r) void'(q.pop_front());
      if (acc && bufb && !(n == 0 && r)) q.push_back(cur);
      if (acc) pend = 1'b0;
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    total++; if (bus_exp.size() != 0 || bus.empty_o !== 1'b1) begin
      bad++; $display("FAIL rnd_drain: got %0d outstanding empty=%b want 0 1", bus_exp.size(), bus.empty_o);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.trans_i = '0;
    bus.ready_i = 1'b0;
    test_reset();
    test_bypass_load();
    test_stalled_store();
    test_full();
    test_order();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40s_lsu_write_buffer.md
# cv32e40s_lsu_write_buffer

Buffers bufferable stores so the response filter can return rvalid to the LSU early, without waiting for the bus. The block sits directly downstream of the LSU response filter's request side and directly upstream of the OBI data interface. It holds up to DEPTH bufferable writes in order. Transfers that are not bufferable pass through only when the buffer is empty, so bus order always equals program order.

## Interface
- DEPTH, default 2, number of buffer entries, legal range 1..8.
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- valid_i  input  1  transfer request from the response filter.
- trans_i  input  obi_data_req_t  transfer attributes. `memtype[0]` is the bufferable bit; `we` is the write bit.
- ready_o  output  1  transfer accepted by this block.
- valid_o  output  1  request to the OBI data interface.
- trans_o  output  obi_data_req_t  transfer presented to the OBI data interface.
- ready_i  input  1  OBI data interface has accepted trans_o.
- busy_o  output  1  buffer holds at least one entry. Used by the controller for fence, WFI and debug-entry drain.
- full_o  output  1  count equals DEPTH.
- empty_o  output  1  count equals 0.

## Operation
- A transfer is bufferable when `trans_i.we && trans_i.memtype[0]`. Reads and non-bufferable writes are never stored.
- State:
  - FIFO of DEPTH obi_data_req_t entries.
  - Read pointer and write pointer, each of width max(1, $clog2(DEPTH)). A pointer wraps explicitly to 0 after DEPTH-1, so DEPTH need not be a power of two.
  - Count of width $clog2(DEPTH+1), range 0..DEPTH.
- Output mux:
  - When count > 0: valid_o = 1 and trans_o = FIFO head.
  - When count = 0: valid_o = valid_i and trans_o = trans_i (bypass).
- ready_o:
  - count = 0, bufferable: 1.
  - count = 0, not bufferable: ready_i.
  - 0 < count < DEPTH, bufferable: 1.
  - 0 < count < DEPTH, not bufferable: 0. The transfer waits for the buffer to drain.
  - count = DEPTH: 0, even if the head pops in the same cycle. This keeps ready_i off the path to ready_o when full.
- Push: occurs when valid_i && ready_o && bufferable, except when count = 0 && ready_i (bypass completes directly). Push writes trans_i at the write pointer and increments the write pointer.
- Pop: occurs when count > 0 && ready_i. Pop increments the read pointer.
- Count update: next count = count + push − pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- busy_o = (count != 0); empty_o = (count == 0); full_o = (count == DEPTH).
- trans_o must not change while valid_o = 1 && !ready_i, as OBI requires:
  - In bypass, this relies on the upstream OBI stability rule on trans_i.
  - A bypassed bufferable store that stalls (ready_i = 0) is pushed. From the next cycle it is presented from the head with identical content.

## Timing
- Reset:
  - count = 0, both pointers = 0, FIFO contents = 0.
  - Outputs: busy_o = 0, full_o = 0, empty_o = 1.
  - valid_o = valid_i and trans_o = trans_i (combinational bypass).
  - ready_o follows the empty-state rules above.
- Latency:
  - Bypass adds zero cycles: valid_i to valid_o and ready_i to ready_o are combinational when empty.
  - A buffered entry appears on trans_o the cycle after push at the earliest, and only once all older entries have popped.
- No combinational path from ready_i to ready_o when count > 0.
- Reset asserted mid-operation discards all buffered entries immediately. The system-level reset owns any loss of pending stores.
- Count never exceeds DEPTH and never underflows. A push while count = DEPTH, or a pop while count = 0, is impossible by construction and is asserted against.

## Test plan
- Empty buffer; load at addr 0x100 with ready_i = 1: valid_o, trans_o.addr = 0x100 and ready_o are all high the same cycle; count stays 0; busy_o = 0.
- Empty buffer; bufferable store at 0x200 with ready_i = 0 for 3 cycles, then 1:
  - ready_o = 1 in cycle 0.
  - count = 1 and busy_o = 1 from cycle 1.
  - trans_o.addr = 0x200 steadily for 4 cycles.
  - Pop in cycle 3; count returns to 0 in cycle 4.
- DEPTH = 2, ready_i = 0; bufferable stores at 0x10, 0x14, 0x18:
  - The first two are accepted; count = 2; full_o = 1.
  - The third sees ready_o = 0 until a pop frees an entry, and is accepted the cycle after count drops to 1.
- Buffered store at 0x20 (count = 1), then a load at 0x30:
  - ready_o = 0 for the load while count = 1.
  - After the pop, the load bypasses.
  - Bus order is 0x20, then 0x30.
- count = 1 (head 0x40); bufferable store at 0x44 in the same cycle ready_i = 1: count stays 1; 0x40 issues this cycle; trans_o.addr = 0x44 next cycle.
- count = 2 with ready_i = 0; pulse rst_n low: count = 0, empty_o = 1 and busy_o = 0 immediately; after release, valid_o follows valid_i.
